// File: rtl/zed64_uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling points and frame size.
package zed64_uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_A   = 4'd7;
    localparam logic [3:0] SAMPLE_B   = 4'd8;
    localparam logic [3:0] SAMPLE_C   = 4'd9;
    localparam logic [3:0] BIT_END    = 4'd15;
    localparam int         DATA_BITS  = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with a registered head entry and an occupancy counter
// one bit wider than the pointers.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_dout;

    logic             w_push_eff;
    logic             w_pop_eff;
    logic [PTR_W-1:0] w_rd_next;
    logic [LVL_W-1:0] w_level_next;
    logic [WIDTH-1:0] w_head_next;

    assign o_full     = (r_level == LVL_W'(DEPTH));
    assign o_empty    = (r_level == {LVL_W{1'b0}});
    assign w_pop_eff  = i_pop && !o_empty;
    assign w_push_eff = i_push && (!o_full || w_pop_eff);
    assign w_rd_next  = w_pop_eff ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

    // Next occupancy and next head; a push lands at the head when nothing older remains.
    always_comb begin
        w_level_next = r_level;
        w_head_next  = r_mem[w_rd_next];
        if (w_push_eff && !w_pop_eff) begin
            w_level_next = r_level + LVL_W'(1);
        end else if (!w_push_eff && w_pop_eff) begin
            w_level_next = r_level - LVL_W'(1);
        end else begin
            w_level_next = r_level;
        end
        if (w_push_eff && (w_rd_next == r_wr_ptr)) begin
            w_head_next = i_din;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Storage, pointers, level and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
            r_dout   <= {WIDTH{1'b0}};
        end else begin
            if (w_push_eff) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
            if (w_level_next != {LVL_W{1'b0}}) begin
                r_dout <= w_head_next;
            end
        end
    end

    assign o_dout  = r_dout;
    assign o_level = r_level;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling with a mid-bit
// majority vote, and a small FIFO presented on a valid/ready interface.
module uart_rx
    import zed64_uart_pkg::*;
#(
    parameter int DIV        = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          btnCpuReset,
    input  logic                          rx_in,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [TICK_W-1:0]    r_tick_cnt;
    rx_state_t            r_state;
    logic [3:0]           r_samp_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic                 r_busy;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_rx_s;
    logic                 w_tick;
    logic                 w_maj;
    rx_state_t            w_state_next;
    logic [3:0]           w_cnt_next;
    logic [2:0]           w_idx_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_samp_a_next;
    logic                 w_samp_b_next;
    logic                 w_push;
    logic                 w_ferr;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;

    assign w_rx_s = r_sync2;
    assign w_tick = (r_tick_cnt == TICK_W'(DIV - 1));
    assign w_maj  = majority3(r_samp_a, r_samp_b, w_rx_s);

    // Input synchronizer and free-running oversample tick divider.
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_tick_cnt <= {TICK_W{1'b0}};
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_tick_cnt <= {TICK_W{1'b0}};
            end else begin
                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
        end
    end

    // Receiver next-state logic; the stop bit is judged at mid-bit so the next start edge is caught early.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_samp_cnt;
        w_idx_next    = r_bit_idx;
        w_shift_next  = r_shift;
        w_samp_a_next = r_samp_a;
        w_samp_b_next = r_samp_b;
        w_push        = 1'b0;
        w_ferr        = 1'b0;
        if (w_tick && (r_state != RX_IDLE) && (r_state != RX_WAIT_IDLE)) begin
            w_cnt_next = r_samp_cnt + 4'd1;
            if (r_samp_cnt == SAMPLE_A) begin
                w_samp_a_next = w_rx_s;
            end else begin
                w_samp_a_next = r_samp_a;
            end
            if (r_samp_cnt == SAMPLE_B) begin
                w_samp_b_next = w_rx_s;
            end else begin
                w_samp_b_next = r_samp_b;
            end
        end else begin
            w_cnt_next = r_samp_cnt;
        end
        case (r_state)
            RX_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = RX_START;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_state_next = RX_IDLE;
                end
            end
            RX_START: begin
                if (w_tick && (r_samp_cnt == SAMPLE_C) && w_maj) begin
                    w_state_next = RX_IDLE;
                end else if (w_tick && (r_samp_cnt == BIT_END)) begin
                    w_state_next = RX_DATA;
                    w_idx_next   = 3'd0;
                end else begin
                    w_state_next = RX_START;
                end
            end
            RX_DATA: begin
                if (w_tick && (r_samp_cnt == SAMPLE_C)) begin
                    w_shift_next = {w_maj, r_shift[DATA_BITS-1:1]};
                end else begin
                    w_shift_next = r_shift;
                end
                if (w_tick && (r_samp_cnt == BIT_END) && (r_bit_idx == 3'(DATA_BITS - 1))) begin
                    w_state_next = RX_STOP;
                end else if (w_tick && (r_samp_cnt == BIT_END)) begin
                    w_idx_next = r_bit_idx + 3'd1;
                end else begin
                    w_state_next = RX_DATA;
                end
            end
            RX_STOP: begin
                if (w_tick && (r_samp_cnt == SAMPLE_C) && w_maj) begin
                    w_push       = 1'b1;
                    w_state_next = RX_IDLE;
                end else if (w_tick && (r_samp_cnt == SAMPLE_C)) begin
                    w_ferr       = 1'b1;
                    w_state_next = RX_WAIT_IDLE;
                end else begin
                    w_state_next = RX_STOP;
                end
            end
            RX_WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_next = RX_IDLE;
                end else begin
                    w_state_next = RX_WAIT_IDLE;
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

    // Receiver state and registered status pulses.
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            r_state     <= RX_IDLE;
            r_samp_cnt  <= 4'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= {DATA_BITS{1'b0}};
            r_samp_a    <= 1'b1;
            r_samp_b    <= 1'b1;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_samp_cnt  <= w_cnt_next;
            r_bit_idx   <= w_idx_next;
            r_shift     <= w_shift_next;
            r_samp_a    <= w_samp_a_next;
            r_samp_b    <= w_samp_b_next;
            r_busy      <= (w_state_next != RX_IDLE);
            r_frame_err <= w_ferr;
            r_overrun   <= w_push && w_full && !w_pop;
        end
    end

    assign w_pop = rx_ready && !w_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (btnCpuReset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_shift_next),
        .o_dout  (rx_data),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx_valid  = !w_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at DIV=4 (one bit = 64 clk): expected bytes are queued
// by the stimulus and a negedge monitor checks each byte as it is popped.
module tb_uart_rx;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       btnCpuReset;
    logic       rx_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [2:0] fifo_level;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pop_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.DIV(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .btnCpuReset(btnCpuReset),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: count status pulses, and compare every popped byte against the scoreboard.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && rx_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got 0x%0h expected no byte", rx_data);
            end else begin
                chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk);
        t_start = cyc;
        rx_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx_in = stop;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 rx_ready = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  lat;
        int  fe0;
        int  ov0;
        int  p0;
        bit  seen;

        rx_in       = 1'b1;
        rx_ready    = 1'b0;
        btnCpuReset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {frame_err, overrun}, 0);
        @(negedge clk);
        btnCpuReset = 1'b1;
        repeat (20) @(negedge clk);

        // 1: 0xA5, check latency from start edge and level before popping.
        seen = 1'b0;
        lat  = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 700; i++) begin
                    @(negedge clk);
                    if (rx_valid && !seen) begin
                        seen = 1'b1;
                        lat  = cyc - t_start;
                    end
                end
            end
        join
        checks++;
        if (!seen || lat < 612 || lat > 624) begin
            errors++;
            $display("FAIL t1_latency: got %0d cycles (seen=%0d) expected 612..624", lat, seen);
        end
        chk("t1_level", fifo_level, 1);
        chk("t1_ferr", fe_cnt, 0);
        exp_q.push_back(8'hA5);
        set_ready(1'b1);
        repeat (8) @(negedge clk);
        chk("t1_drain", exp_q.size(), 0);
        chk("t1_level0", fifo_level, 0);

        // 2: short low glitch is a false start.
        fe0 = fe_cnt;
        p0  = pop_cnt;
        rx_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_busy_hi", busy, 1);
        repeat (10) @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("t2_busy_lo", busy, 0);
        chk("t2_nopush", pop_cnt - p0, 0);
        chk("t2_level", fifo_level, 0);
        chk("t2_flags", (fe_cnt - fe0) + ov_cnt, 0);

        // 3: bad stop bit, then a good frame.
        send_frame(8'h3C, 1'b0);
        chk("t3_busy_held", busy, 1);
        chk("t3_ferr", fe_cnt - fe0, 1);
        chk("t3_level", fifo_level, 0);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("t3_busy_lo", busy, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        repeat (BIT) @(negedge clk);
        chk("t3_drain", exp_q.size(), 0);
        chk("t3_ferr_once", fe_cnt - fe0, 1);

        // 4: line held low from reset release.
        @(negedge clk);
        btnCpuReset = 1'b0;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        fe0 = fe_cnt;
        p0  = pop_cnt;
        btnCpuReset = 1'b1;
        repeat (30 * BIT) @(negedge clk);
        chk("t4_ferr", fe_cnt - fe0, 1);
        chk("t4_nodata", pop_cnt - p0, 0);
        chk("t4_valid", rx_valid, 0);
        rx_in = 1'b1;
        repeat (BIT) @(negedge clk);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (BIT) @(negedge clk);
        chk("t4_drain", exp_q.size(), 0);

        // 5: fill the FIFO, fifth byte overruns.
        set_ready(1'b0);
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        for (int b = 1; b <= 4; b++) exp_q.push_back(8'(b));
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        repeat (BIT) @(negedge clk);
        chk("t5_level", fifo_level, 4);
        chk("t5_overrun", ov_cnt - ov0, 1);
        chk("t5_ferr", fe_cnt - fe0, 0);
        chk("t5_head", rx_data, 8'h01);
        set_ready(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!rx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_drained_valid", seen, 1);
        chk("t5_level0", fifo_level, 0);
        chk("t5_queue", exp_q.size(), 0);

        // 6: reset in the middle of data bit 3 with a byte waiting in the FIFO.
        set_ready(1'b0);
        send_frame(8'h5A, 1'b1);
        repeat (32) @(negedge clk);
        chk("t6_pre_data", rx_data, 8'h5A);
        chk("t6_pre_level", fifo_level, 1);
        rx_in = 1'b0;
        repeat (4 * BIT + 20) @(negedge clk);
        chk("t6_pre_busy", busy, 1);
        btnCpuReset = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", rx_valid, 0);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_data", rx_data, 0);
        chk("t6_rst_flags", {frame_err, overrun}, 0);
        rx_in = 1'b1;
        @(negedge clk);
        btnCpuReset = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        set_ready(1'b1);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1);
        repeat (BIT) @(negedge clk);
        chk("t6_drain", exp_q.size(), 0);
        chk("t6_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
